moore_up_counter: RTL and testbench

Parameterised Moore-style up counter, the counting-up counterpart to the existing down counter in the FSM lab design. It counts from 0 to a terminal value under an enable. A terminal-count flag and the FSM state are decoded only from registered state. It shares the clk/reset/enable interface with the down counter, so both can run from the same stimulus in a common bench.

---
 rtl/moore_counter_pkg.sv | 11 +
 rtl/moore_up_counter.sv | 59 +++++
 tb/tb_moore_up_counter.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/moore_counter_pkg.sv
// moore_counter_pkg: state encoding and default sizing shared by the up/down counters and their benches.
package moore_counter_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    TERM  = 2'b11
  } state_e;
  localparam int DEF_WIDTH = 4;
  localparam int DEF_MAX = 15;
endpackage

// File: rtl/moore_up_counter.sv
// moore_up_counter: Moore up counter 0..MAX with clear/enable; outputs decoded from registers only.
// Define MOORE_UP_COUNTER_SAT_EN to saturate at MAX instead of wrapping to 0.
module moore_up_counter
  import moore_counter_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int MAX = DEF_MAX
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             clear,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             running,
  output logic [1:0]       state
);
`ifdef MOORE_UP_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);
  if (MAX < 1 || MAX > (1 << WIDTH) - 1) begin : g_max_check
    $error("moore_up_counter: MAX out of range for WIDTH");
  end
  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d, nxt;
  always_comb begin
    nxt     = count_q + WIDTH'(1);
    state_d = state_q;
    count_d = count_q;
    if (clear) begin
      state_d = IDLE;
      count_d = '0;
    end else if (enable && state_q == TERM) begin
      state_d = SAT ? TERM : RUN;
      count_d = SAT ? count_q : '0;
    end else if (enable) begin
      state_d = (nxt == MAX_V) ? TERM : RUN;
      count_d = nxt;
    end else if (state_q == RUN) begin
      state_d = PAUSE;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end
  assign count   = count_q;
  assign state   = state_q;
  assign tc      = state_q == TERM;
  assign running = state_q == RUN;
endmodule

// File: tb/tb_moore_up_counter.sv
// tb_moore_up_counter: scoreboard bench for moore_up_counter (default MAX) plus a MAX=1 instance.
module tb_moore_up_counter;
  import moore_counter_pkg::*;
  localparam int W = DEF_WIDTH;
  localparam int M = DEF_MAX;
`ifdef MOORE_UP_COUNTER_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, enable = 1'b0, clear = 1'b0, en1 = 1'b0, clr1 = 1'b0;
  logic [W-1:0] count, count1;
  logic tc, running, tc1, running1;
  logic [1:0] state, state1;
  int checks = 0, errors = 0;
  logic [W+3:0] sb[$];
  logic [W-1:0] m_count = '0;
  state_e m_state = IDLE;
  always #5 clk = ~clk;
  moore_up_counter #(.WIDTH(W), .MAX(M)) dut (
    .clk(clk), .reset(reset), .enable(enable), .clear(clear),
    .count(count), .tc(tc), .running(running), .state(state)
  );
  moore_up_counter #(.WIDTH(W), .MAX(1)) dut1 (
    .clk(clk), .reset(reset), .enable(en1), .clear(clr1),
    .count(count1), .tc(tc1), .running(running1), .state(state1)
  );
  // Reference behaviour of the counter, advanced once per driven edge.
  task automatic model(input logic en, input logic clr);
    if (clr) begin
      m_count = '0;
      m_state = IDLE;
    end else if (en && m_state == TERM) begin
      if (!SAT) begin
        m_count = '0;
        m_state = RUN;
      end
    end else if (en) begin
      m_count = m_count + 1'b1;
      m_state = (m_count == W'(M)) ? TERM : RUN;
    end else if (m_state == RUN) begin
      m_state = PAUSE;
    end
  endtask
  task automatic drive(input logic en, input logic clr);
    enable = en;
    clear = clr;
    model(en, clr);
    sb.push_back({m_count, m_state, m_state == TERM, m_state == RUN});
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset();
    logic [W+3:0] e;
    for (int i = 0; i < 4; i++) begin
      #12;
      checks++;
      if ({count, state, tc, running} !== {W'(0), 2'b00, 1'b0, 1'b0}) begin
        errors++;
        $display("FAIL reset_hold[%0d] got %h exp %h", i, {count, state, tc, running}, {W'(0), 4'b0});
      end
    end
    @(posedge clk);
    #2 reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      drive(1'b0, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({count, state, tc, running} !== e) begin
        errors++;
        $display("FAIL post_release[%0d] got %h exp %h", i, {count, state, tc, running}, e);
      end
    end
  endtask
  task automatic test_full_count();
    logic [W+3:0] e;
    for (int i = 1; i <= M + (SAT ? 5 : 1); i++) begin
      drive(1'b1, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({count, state, tc, running} !== e) begin
        errors++;
        $display("FAIL full_count[%0d] got %h exp %h", i, {count, state, tc, running}, e);
      end
      if (i == M) begin
        checks++;
        if (count !== W'(M) || tc !== 1'b1) begin
          errors++;
          $display("FAIL terminal got count=%0d tc=%b exp count=%0d tc=1", count, tc, M);
        end
      end
    end
    checks++;
    if (SAT ? (count !== W'(M) || tc !== 1'b1) : (count !== '0 || state !== 2'b01 || tc !== 1'b0)) begin
      errors++;
      $display("FAIL after_terminal got count=%0d state=%0d tc=%b", count, state, tc);
    end
    drive(1'b0, 1'b1);
    e = sb.pop_front();
    checks++;
    if ({count, state, tc, running} !== e) begin
      errors++;
      $display("FAIL clear_to_idle got %h exp %h", {count, state, tc, running}, e);
    end
  endtask
  task automatic test_pause_resume();
    logic [W+3:0] e;
    for (int i = 0; i < 8; i++) begin
      drive(i < 3 || i == 7, 1'b0);
      e = sb.pop_front();
      checks++;
      if ({count, state, tc, running} !== e) begin
        errors++;
        $display("FAIL pause_resume[%0d] got %h exp %h", i, {count, state, tc, running}, e);
      end
      if (i == 6) begin
        checks++;
        if (count !== W'(3) || state !== 2'b10 || running !== 1'b0) begin
          errors++;
          $display("FAIL paused got count=%0d state=%0d run=%b exp 3 2 0", count, state, running);
        end
      end
    end
    checks++;
    if (count !== W'(4) || state !== 2'b01) begin
      errors++;
      $display("FAIL resumed got count=%0d state=%0d exp 4 1", count, state);
    end
  endtask
  task automatic test_clear_priority();
    logic [W+3:0] e;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, i == 5);
      e = sb.pop_front();
      checks++;
      if ({count, state, tc, running} !== e) begin
        errors++;
        $display("FAIL clear_prio[%0d] got %h exp %h", i, {count, state, tc, running}, e);
      end
    end
    checks++;
    if (count !== '0 || state !== 2'b00) begin
      errors++;
      $display("FAIL clear_wins got count=%0d state=%0d exp 0 0", count, state);
    end
  endtask
  task automatic test_async_reset();
    logic [W+3:0] e;
    for (int i = 0; i < 7; i++) begin
      drive(1'b1, 1'b0);
      void'(sb.pop_front());
    end
    checks++;
    if (count !== W'(7)) begin
      errors++;
      $display("FAIL pre_reset got count=%0d exp 7", count);
    end
    #2 reset = 1'b0;
    #1;
    m_count = '0;
    m_state = IDLE;
    checks++;
    if ({count, state, tc, running} !== {W'(0), 4'b0}) begin
      errors++;
      $display("FAIL async_reset got %h exp %h", {count, state, tc, running}, {W'(0), 4'b0});
    end
    @(posedge clk);
    #3 reset = 1'b1;
    drive(1'b1, 1'b0);
    e = sb.pop_front();
    checks++;
    if ({count, state, tc, running} !== e || count !== W'(1)) begin
      errors++;
      $display("FAIL resume_after_reset got %h exp %h", {count, state, tc, running}, e);
    end
  endtask
  task automatic test_small_terminal();
    enable = 1'b0;
    clear = 1'b0;
    checks++;
    if (count1 !== '0 || state1 !== 2'b00) begin
      errors++;
      $display("FAIL max1_idle got count=%0d state=%0d exp 0 0", count1, state1);
    end
    en1 = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (count1 !== W'(1) || tc1 !== 1'b1 || state1 !== 2'b11) begin
      errors++;
      $display("FAIL max1_first got count=%0d tc=%b state=%0d exp 1 1 3", count1, tc1, state1);
    end
    @(posedge clk);
    #1;
    checks++;
    if (SAT ? (count1 !== W'(1) || tc1 !== 1'b1) : (count1 !== '0 || tc1 !== 1'b0 || state1 !== 2'b01)) begin
      errors++;
      $display("FAIL max1_second got count=%0d tc=%b state=%0d", count1, tc1, state1);
    end
    en1 = 1'b0;
  endtask
  initial begin
    test_reset();
    test_full_count();
    test_pause_resume();
    test_clear_priority();
    test_async_reset();
    test_small_terminal();
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
